// File: rtl/mips_pkg.sv
// Shared MIPS core definitions.
// Datapath width, fetch bubble word, IF/ID entry layout.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] nextpc;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: in-order circular queue
// between fetch and decode with registered stall.
module if_id_buffer
  import mips_pkg::*;
#(
  parameter int unsigned     XLEN_P   = mips_pkg::XLEN,
  parameter int unsigned     DEPTH    = 2,
  parameter logic [XLEN_P-1:0] NOP_W  = mips_pkg::NOP_WORD,
  localparam int unsigned    PW       = $clog2(DEPTH),
  localparam int unsigned    CW       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN_P-1:0] f_instruction,
  input  logic [XLEN_P-1:0] f_nextpc,
  input  logic              f_hit,
  input  logic              flush,
  output logic              f_stall,
  output logic [XLEN_P-1:0] d_instruction,
  output logic [XLEN_P-1:0] d_nextpc,
  output logic              d_valid,
  input  logic              d_ready,
  output logic [CW-1:0]     count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN_P-1:0] ins_q [DEPTH];
  logic [XLEN_P-1:0] npc_q [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          stall_q, stall_d;

  logic push;
  logic pop;
  logic nonempty;

  assign nonempty = (count_q != '0);

  // Handshake decisions; full blocks push even when a pop coincides.
  always_comb begin
    push = f_hit && (count_q != FULL) && !flush;
    pop  = nonempty && d_ready && !flush;
  end

  // Next-state for pointers, occupancy and stall.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      count_d = count_q + {{(CW-1){1'b0}}, push}
                        - {{(CW-1){1'b0}}, pop};
    end
    stall_d = (count_d == FULL);
  end

  // Control state register; reset wins over flush and traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      stall_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end

  // Entry storage; plain flops, no reset needed.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      ins_q[wptr_q] <= f_instruction;
      npc_q[wptr_q] <= f_nextpc;
    end
  end

  // Decode-side view, driven from registers only.
  always_comb begin
    d_valid       = nonempty;
    d_instruction = NOP_W;
    d_nextpc      = '0;
    if (nonempty) begin
      d_instruction = ins_q[rptr_q];
      d_nextpc      = npc_q[rptr_q];
    end
  end

  assign f_stall = stall_q;
  assign count   = count_q;

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for the IF/ID buffer.
// Vector table plus short hand sequences.
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] f_instruction;
  logic [31:0] f_nextpc;
  logic        f_hit;
  logic        flush;
  logic        f_stall;
  logic [31:0] d_instruction;
  logic [31:0] d_nextpc;
  logic        d_valid;
  logic        d_ready;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_buffer #(.DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .f_instruction (f_instruction),
    .f_nextpc      (f_nextpc),
    .f_hit         (f_hit),
    .flush         (flush),
    .f_stall       (f_stall),
    .d_instruction (d_instruction),
    .d_nextpc      (d_nextpc),
    .d_valid       (d_valid),
    .d_ready       (d_ready),
    .count         (count)
  );

  typedef struct {
    logic        rst;
    logic        hit;
    logic [31:0] ins;
    logic [31:0] npc;
    logic        fl;
    logic        rdy;
    logic        e_v;
    logic [31:0] e_ins;
    logic [31:0] e_npc;
    logic        e_st;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t vq[$];

  localparam logic [31:0] A = 32'hAAAA_0001;
  localparam logic [31:0] B = 32'hBBBB_0002;
  localparam logic [31:0] C = 32'hCCCC_0003;
  localparam logic [31:0] D = 32'hDDDD_0004;
  localparam logic [31:0] E = 32'hEEEE_0005;
  localparam logic [31:0] F = 32'h1234_5678;

  task automatic add(
    input logic r, input logic h,
    input logic [31:0] i, input logic [31:0] n,
    input logic fl, input logic rd,
    input logic v, input logic [31:0] ei,
    input logic [31:0] en, input logic st,
    input logic [1:0] c);
    vec_t t;
    t.rst = r;  t.hit = h;  t.ins = i;
    t.npc = n;  t.fl = fl;  t.rdy = rd;
    t.e_v = v;  t.e_ins = ei;  t.e_npc = en;
    t.e_st = st;  t.e_cnt = c;
    vq.push_back(t);
  endtask

  task automatic chk(
    input string nm, input int idx,
    input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h",
               nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input vec_t t);
    chk("d_valid", idx, 32'(d_valid), 32'(t.e_v));
    chk("d_instruction", idx, d_instruction, t.e_ins);
    chk("d_nextpc", idx, d_nextpc, t.e_npc);
    chk("f_stall", idx, 32'(f_stall), 32'(t.e_st));
    chk("count", idx, 32'(count), 32'(t.e_cnt));
  endtask

  initial begin
    rst = 1'b1;
    f_hit = 1'b0;
    f_instruction = '0;
    f_nextpc = '0;
    flush = 1'b0;
    d_ready = 1'b0;

    // rst hit ins npc fl rdy | v ins npc st cnt
    // reset, idle
    add(1,0,0,0,0,0, 0,0,0,0,0);
    add(1,0,0,0,0,0, 0,0,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,0);
    // streaming
    add(0,1,32'h2008_0005,4,0,1, 1,32'h2008_0005,4,0,1);
    add(0,1,32'h2008_0006,8,0,1, 1,32'h2008_0006,8,0,1);
    add(0,1,32'h2008_0007,12,0,1, 1,32'h2008_0007,12,0,1);
    add(0,1,32'h2008_0008,16,0,1, 1,32'h2008_0008,16,0,1);
    add(0,0,0,0,0,1, 0,0,0,0,0);
    // back-pressure, C dropped
    add(0,1,A,100,0,0, 1,A,100,0,1);
    add(0,1,B,104,0,0, 1,A,100,1,2);
    add(0,1,C,108,0,0, 1,A,100,1,2);
    add(0,0,0,0,0,1, 1,B,104,0,1);
    add(0,0,0,0,0,1, 0,0,0,0,0);
    // full with simultaneous pop
    add(0,1,A,100,0,0, 1,A,100,0,1);
    add(0,1,B,104,0,0, 1,A,100,1,2);
    add(0,1,D,200,0,1, 1,B,104,0,1);
    add(0,1,D,200,0,0, 1,B,104,1,2);
    add(0,0,0,0,0,1, 1,D,200,0,1);
    add(0,0,0,0,0,1, 0,0,0,0,0);
    // flush kills A,B and E
    add(0,1,A,100,0,0, 1,A,100,0,1);
    add(0,1,B,104,0,0, 1,A,100,1,2);
    add(0,1,E,300,1,1, 0,0,0,0,0);
    add(0,0,0,0,0,1, 0,0,0,0,0);
    // reset mid-operation
    add(0,1,A,100,0,0, 1,A,100,0,1);
    add(0,1,B,104,0,0, 1,A,100,1,2);
    add(1,1,C,108,0,0, 0,0,0,0,0);
    add(0,1,D,200,0,0, 1,D,200,0,1);
    add(0,0,0,0,0,1, 0,0,0,0,0);

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst;
      f_hit = vq[i].hit;
      f_instruction = vq[i].ins;
      f_nextpc = vq[i].npc;
      flush = vq[i].fl;
      d_ready = vq[i].rdy;
      @(posedge clk);
      #1;
      chk_all(i, vq[i]);
    end

    // No combinational path from fetch to decode.
    @(negedge clk);
    rst = 1'b0;
    flush = 1'b0;
    d_ready = 1'b0;
    f_hit = 1'b1;
    f_instruction = F;
    f_nextpc = 32'h40;
    #1;
    chk("comb_valid", 100, 32'(d_valid), 32'd0);
    chk("comb_ins", 100, d_instruction, 32'h0);
    @(posedge clk);
    #1;
    chk("late_ins", 101, d_instruction, F);
    chk("late_npc", 101, d_nextpc, 32'h40);

    // Drain, then d_ready on empty is harmless.
    @(negedge clk);
    f_hit = 1'b0;
    d_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("drain_cnt", 102, 32'(count), 32'd0);
    @(posedge clk);
    #1;
    chk("empty_rdy_cnt", 103, 32'(count), 32'd0);
    chk("empty_rdy_v", 103, 32'(d_valid), 32'd0);

    // rst beats flush and push together.
    @(negedge clk);
    f_hit = 1'b1;
    f_instruction = A;
    f_nextpc = 32'h80;
    d_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_cnt", 104, 32'(count), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    flush = 1'b1;
    f_instruction = B;
    @(posedge clk);
    #1;
    chk("rst_fl_cnt", 105, 32'(count), 32'd0);
    chk("rst_fl_stall", 105, 32'(f_stall), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Pipeline buffer between the fetch stage and the decode stage of the MIPS core.
- Captures each instruction word and its PC+4 (nextpc) that fetch presents on a cache hit.
- Holds up to DEPTH entries and presents them in order to decode through a valid/ready handshake.
- Back-pressures fetch with a registered stall, and discards all wrong-path entries when a taken branch flushes the front end.

Parameters:
- XLEN, 32: width of the instruction and nextpc fields.
- DEPTH, 2: number of buffer entries. Legal values are 2 or 4 (power of two).
- NOP_WORD, 32'h0000_0000: word driven on d_instruction while the buffer is empty (MIPS sll $0,$0,0).

Ports:
- clk  in  1  rising-edge clock; one clock domain.
- rst  in  1  reset: synchronous, active-high.
- f_instruction  in  XLEN  instruction word from fetch.
- f_nextpc  in  XLEN  PC+4 from fetch, paired with f_instruction.
- f_hit  in  1  fetch word is valid this cycle (I-cache hit).
- flush  in  1  taken branch (pc_src); kills all buffered and incoming words.
- f_stall  out  1  fetch must hold its PC; registered, high when the buffer is full.
- d_instruction  out  XLEN  head-entry instruction, or NOP_WORD when empty.
- d_nextpc  out  XLEN  head-entry nextpc, or 0 when empty.
- d_valid  out  1  head entry is valid.
- d_ready  in  1  decode accepts the head entry this cycle (hazard unit not stalling).
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=1 at a clk edge): count=0, read/write pointers=0, d_valid=0, d_instruction=NOP_WORD, d_nextpc=0, f_stall=0. Reset overrides every other input, including when asserted mid-operation.
- Enqueue: push happens when f_hit=1, count<DEPTH and flush=0. The entry is written at the write pointer, and the write pointer increments modulo DEPTH.
- Dequeue: pop happens when d_valid=1, d_ready=1 and flush=0. The read pointer increments modulo DEPTH.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Count update: count_next = count + push - pop. Width is sized so that count=DEPTH is representable.
- Latency: a word pushed at edge N is visible on the d_* outputs after edge N (one cycle) if the buffer was empty. There is no combinational path from f_* inputs to d_* outputs.
- f_stall is registered and equals (count_next==DEPTH). A push is never accepted while count==DEPTH, even if a pop occurs in the same cycle. This keeps f_stall free of combinational dependence on d_ready.
- Dropped words: while f_stall=1, fetch holds its PC. Any f_hit seen while full is ignored and no data is overwritten.
- Outputs are derived from registers only:
  - d_valid = (count!=0).
  - d_instruction/d_nextpc = entry at the read pointer when count!=0; otherwise NOP_WORD/0.
- Flush (flush=1 at an edge, rst=0): count->0, both pointers->0, f_stall->0.
  - The same-cycle f_hit word is discarded as wrong-path.
  - A same-cycle d_ready is ignored; that head entry is not counted as consumed.
  - From the next cycle, d_valid=0 and d_instruction=NOP_WORD.
- Priority: rst > flush > push/pop.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full versus empty is distinguished by count only.
- d_ready while empty: no effect.
- f_hit=0: no push, regardless of the f_instruction/f_nextpc values, which are don't-care.
- Storage is plain flops; no reset is required on the data array (only pointers, count and f_stall are reset).

Decomposition:
- Shared package mips_pkg holds XLEN=32, NOP_WORD=32'h0000_0000, and a struct if_id_entry_t {instruction[XLEN-1:0], nextpc[XLEN-1:0]} reused by the decode stage.
- No sub-module. The circular buffer is small enough to live inline; a separate FIFO instance would only add port plumbing.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, then rst=0, f_hit=0 -> d_valid=0, d_instruction=32'h0, d_nextpc=0, f_stall=0, count=0.
2. Streaming: d_ready=1, f_hit=1 for 4 cycles with instruction 32'h2008_0005/06/07/08 and nextpc 4,8,12,16 -> each word appears on d_* one cycle later in order, count stays 1, f_stall never rises.
3. Back-pressure: d_ready=0, f_hit=1 with words A,B,C:
   - f_stall=1 after the 2nd push; count=2; C is ignored.
   - Then d_ready=1 -> A, then B, are delivered; f_stall drops the cycle after the first pop.
4. Full with simultaneous pop: count=2, d_ready=1, f_hit=1 word D -> pop occurs, D is not accepted, count=1. D is accepted on the next cycle.
5. Flush: count=2 holding A,B, and in the same cycle flush=1, f_hit=1 word E, d_ready=1 -> next cycle count=0, d_valid=0, d_instruction=32'h0. Neither E nor B ever appears on d_*.
6. Reset mid-operation: count=2, rst=1 together with f_hit=1 -> next cycle count=0, f_stall=0, d_valid=0. Pushes resume normally after rst=0.
